// File: rtl/xbar_rr_switch.sv
// Registered N-port NoC crossbar with per-output round-robin arbitration,
// valid/ready handshakes, one-flit output registers and a saturating drop counter.
module xbar_rr_switch #(
    parameter int N  = 5,
    parameter int LL = 16,
    parameter int DW = 3,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_dest,
    input  logic [N*LL-1:0] in_data,
    output logic [N-1:0]    in_ready,
    output logic [N-1:0]    out_valid,
    output logic [N*LL-1:0] out_data,
    input  logic [N-1:0]    out_ready,
    output logic [CW-1:0]   drop_cnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int NW = $clog2(N + 1);
    localparam int SW = CW + NW;
    localparam logic [CW-1:0] DROP_MAX = {CW{1'b1}};

    logic [N-1:0]    r_outValid;
    logic [N*LL-1:0] r_outData;
    logic [CW-1:0]   r_dropCnt;
    logic [PW-1:0]   r_ptr [N];

    logic [DW-1:0]   w_dest [N];
    logic [N-1:0]    w_bad;
    logic [N-1:0]    w_free;
    logic [N-1:0]    w_req [N];
    logic [N-1:0]    w_grantValid;
    logic [PW-1:0]   w_grantIdx [N];
    logic [LL-1:0]   w_grantData [N];
    logic [N-1:0]    w_won;
    logic [NW-1:0]   w_badCount;
    logic [SW-1:0]   w_dropSum;
    logic [CW-1:0]   w_dropNext;

    // Returns {found, index} of the first requester at or after ptr, wrapping modulo N.
    function automatic logic [PW:0] rrPick(input logic [N-1:0] req, input logic [PW-1:0] ptr);
        logic [PW:0] pick;
        int          idx;
        pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) pick = {1'b1, PW'(idx)};
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_dest[i] = in_dest[i*DW +: DW];
            w_bad[i]  = in_valid[i] && (32'(in_dest[i*DW +: DW]) >= 32'(N));
        end
    end

    assign w_free = ~r_outValid | out_ready;

    always_comb begin
        for (int o = 0; o < N; o++) begin
            w_req[o] = '0;
            for (int i = 0; i < N; i++) begin
                w_req[o][i] = in_valid[i] && (w_dest[i] == DW'(o));
            end
        end
    end

    always_comb begin
        for (int o = 0; o < N; o++) begin
            {w_grantValid[o], w_grantIdx[o]} = rrPick(w_req[o], r_ptr[o]);
            w_grantData[o] = in_data[int'(w_grantIdx[o])*LL +: LL];
        end
    end

    // A grant only becomes a handshake when its output slot can take the flit.
    always_comb begin
        w_won = '0;
        for (int o = 0; o < N; o++) begin
            if (w_grantValid[o] && w_free[o]) w_won[w_grantIdx[o]] = 1'b1;
        end
    end

    assign in_ready = (w_won | w_bad) & {N{rst_n}};

    always_comb begin
        w_badCount = '0;
        for (int i = 0; i < N; i++) begin
            w_badCount = w_badCount + NW'(w_bad[i]);
        end
        w_dropSum  = SW'(r_dropCnt) + SW'(w_badCount);
        w_dropNext = (w_dropSum > SW'(DROP_MAX)) ? DROP_MAX : w_dropSum[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= '0;
            r_outData  <= '0;
            r_dropCnt  <= '0;
            for (int o = 0; o < N; o++) r_ptr[o] <= '0;
        end else begin
            r_dropCnt <= w_dropNext;
            for (int o = 0; o < N; o++) begin
                if (w_grantValid[o] && w_free[o]) begin
                    r_outValid[o]          <= 1'b1;
                    r_outData[o*LL +: LL]  <= w_grantData[o];
                    r_ptr[o]               <= (w_grantIdx[o] == PW'(N - 1)) ? '0 : w_grantIdx[o] + PW'(1);
                end else if (w_free[o]) begin
                    r_outValid[o] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign drop_cnt  = r_dropCnt;

endmodule

// File: tb/tb_xbar_rr_switch.sv
// Scoreboard bench for xbar_rr_switch: a queue-based reference model predicts
// handshakes and per-output flit order; a separate monitor checks delivered flits.
module tb_xbar_rr_switch;

    localparam int N  = 5;
    localparam int LL = 16;
    localparam int DW = 3;
    localparam int CW = 2;
    localparam int DROP_MAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    in_valid = '0;
    logic [N*DW-1:0] in_dest = '0;
    logic [N*LL-1:0] in_data = '0;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    out_valid;
    logic [N*LL-1:0] out_data;
    logic [N-1:0]    out_ready = '0;
    logic [CW-1:0]   drop_cnt;

    int compared = 0;
    int failed   = 0;

    logic [LL-1:0] sbQ [N][$];
    logic [N-1:0]  mValid;
    logic [N-1:0]  mAccepted;
    int            mPtr [N];
    int            mDrop;
    logic [LL-1:0] monExp;
    logic [N-1:0]  expOrder [4];

    always #5 clk = ~clk;

    xbar_rr_switch #(.N(N), .LL(LL), .DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int destOf(input int i);
        return int'(in_dest[i*DW +: DW]);
    endfunction

    task automatic setInput(input int i, input int dest, input logic [LL-1:0] data);
        in_valid[i]          = 1'b1;
        in_dest[i*DW +: DW]  = DW'(dest);
        in_data[i*LL +: LL]  = data;
    endtask

    task automatic modelReset();
        mValid    = '0;
        mAccepted = '0;
        mDrop     = 0;
        for (int o = 0; o < N; o++) begin
            mPtr[o] = 0;
            sbQ[o].delete();
        end
    endtask

    // Each output serves the requester closest (cyclically) after the one it last served.
    task automatic modelStep();
        int winner [N];
        int best;
        int d;
        int nbad;
        logic [N-1:0] free;
        logic [N-1:0] expReady;
        checkOutput("model_out_valid", 64'(out_valid), 64'(mValid));
        checkOutput("model_drop_cnt", 64'(drop_cnt), 64'(mDrop));
        nbad = 0;
        expReady = '0;
        for (int o = 0; o < N; o++) free[o] = !mValid[o] || out_ready[o];
        for (int o = 0; o < N; o++) begin
            winner[o] = -1;
            best = N;
            for (int i = 0; i < N; i++) begin
                if (in_valid[i] && destOf(i) == o) begin
                    d = (i - mPtr[o] + N) % N;
                    if (d < best) begin
                        best = d;
                        winner[o] = i;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (in_valid[i]) begin
                d = destOf(i);
                if (d >= N) begin
                    expReady[i] = 1'b1;
                    nbad++;
                end else if (winner[d] == i && free[d]) begin
                    expReady[i] = 1'b1;
                end
            end
        end
        checkOutput("model_in_ready", 64'(in_ready), 64'(expReady));
        mAccepted = expReady;
        for (int o = 0; o < N; o++) begin
            if (winner[o] >= 0 && free[o]) begin
                sbQ[o].push_back(in_data[winner[o]*LL +: LL]);
                mValid[o] = 1'b1;
                mPtr[o]   = (winner[o] + 1) % N;
            end else if (free[o]) begin
                mValid[o] = 1'b0;
            end
        end
        mDrop = (mDrop + nbad > DROP_MAX) ? DROP_MAX : mDrop + nbad;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            if (!in_valid[i] || mAccepted[i]) begin
                in_valid[i] = ($urandom_range(0, 99) < 60);
                if ($urandom_range(0, 9) == 0)
                    in_dest[i*DW +: DW] = DW'($urandom_range(N, (1 << DW) - 1));
                else
                    in_dest[i*DW +: DW] = DW'($urandom_range(0, N - 1));
                in_data[i*LL +: LL] = LL'($urandom);
            end
        end
        out_ready = N'($urandom) | N'($urandom);
    endtask

    always @(negedge clk) begin
        #1;
        if (rst_n) modelStep();
    end

    // Monitor: a flit leaves an output whenever valid and ready meet.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int o = 0; o < N; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    if (sbQ[o].size() == 0) begin
                        checkOutput($sformatf("out%0d_unexpected", o), 64'(out_valid[o]), 64'd0);
                    end else begin
                        monExp = sbQ[o].pop_front();
                        checkOutput($sformatf("out%0d_data", o), 64'(out_data[o*LL +: LL]), 64'(monExp));
                    end
                end
            end
        end
    end

    initial begin
        #1;
        rst_n = 1'b0;
        modelReset();
        setInput(0, 0, 16'h1234);
        out_ready = '1;
        #2;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        in_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin contention on Eject
        @(posedge clk); #1;
        setInput(0, 4, 16'h1000);
        setInput(1, 4, 16'h1100);
        setInput(4, 4, 16'h1400);
        expOrder[0] = 5'b00001;
        expOrder[1] = 5'b00010;
        expOrder[2] = 5'b10000;
        expOrder[3] = 5'b00001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #2;
            checkOutput($sformatf("rr_grant%0d", k), 64'(in_ready), 64'(expOrder[k]));
            @(posedge clk); #1;
            for (int i = 0; i < N; i++)
                if (expOrder[k][i]) in_data[i*LL +: LL] = in_data[i*LL +: LL] + 16'h0001;
        end
        in_valid = '0;
        repeat (2) @(posedge clk);
        #1;

        // Single flit
        setInput(0, 3, 16'hA5A5);
        @(negedge clk); #2;
        checkOutput("single_in_ready", 64'(in_ready), 64'b00001);
        @(posedge clk); #1;
        in_valid = '0;
        @(negedge clk); #2;
        checkOutput("single_out_valid", 64'(out_valid), 64'b01000);
        checkOutput("single_out_data", 64'(out_data[3*LL +: LL]), 64'hA5A5);

        // Backpressure on output 2
        @(posedge clk); #1;
        out_ready = 5'b11011;
        setInput(0, 2, 16'h0001);
        @(negedge clk); #2;
        checkOutput("bp_load_ready", 64'(in_ready), 64'b00001);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        setInput(1, 2, 16'h0002);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #2;
            checkOutput("bp_stall_ready", 64'(in_ready[1]), 64'd0);
            checkOutput("bp_hold_data", 64'(out_data[2*LL +: LL]), 64'h0001);
            @(posedge clk); #1;
        end
        out_ready = '1;
        @(negedge clk); #2;
        checkOutput("bp_release_ready", 64'(in_ready[1]), 64'd1);
        @(posedge clk); #1;
        in_valid = '0;
        @(negedge clk); #2;
        checkOutput("bp_new_data", 64'(out_data[2*LL +: LL]), 64'h0002);

        // Full permutation
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) setInput(i, N - 1 - i, 16'hC000 + LL'(i));
        @(negedge clk); #2;
        checkOutput("perm_in_ready", 64'(in_ready), 64'b11111);
        @(posedge clk); #1;
        in_valid = '0;
        @(negedge clk); #2;
        checkOutput("perm_out_valid", 64'(out_valid), 64'b11111);
        for (int o = 0; o < N; o++)
            checkOutput($sformatf("perm_data%0d", o), 64'(out_data[o*LL +: LL]), 64'(16'hC000 + LL'(N - 1 - o)));

        // Bad destination with saturating drop counter
        @(posedge clk); #1;
        setInput(2, 7, 16'hBEEF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #2;
            checkOutput("bad_in_ready", 64'(in_ready), 64'b00100);
            @(posedge clk); #1;
            checkOutput($sformatf("bad_drop%0d", k), 64'(drop_cnt), 64'((k + 1 > DROP_MAX) ? DROP_MAX : k + 1));
        end
        in_valid = '0;

        // Randomised traffic
        for (int cyc = 0; cyc < 400; cyc++) begin
            applyStimulus();
            @(posedge clk); #1;
        end
        in_valid  = '0;
        out_ready = '1;
        repeat (3) @(posedge clk);
        #1;
        for (int o = 0; o < N; o++)
            checkOutput($sformatf("sb_drain%0d", o), 64'(sbQ[o].size()), 64'd0);
        checkOutput("drain_out_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset with every output full
        for (int i = 0; i < N; i++) setInput(i, N - 1 - i, 16'hE000 + LL'(i));
        @(posedge clk); #1;
        in_valid  = '0;
        out_ready = '0;
        #2;
        checkOutput("pre_reset_valid", 64'(out_valid), 64'b11111);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_out_valid", 64'(out_valid), 64'd0);
        checkOutput("async_drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = '1;
        setInput(3, 1, 16'hD003);
        setInput(2, 1, 16'hD002);
        @(negedge clk); #2;
        checkOutput("post_rst_lowest", 64'(in_ready), 64'b00100);
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        @(negedge clk); #2;
        checkOutput("post_rst_next", 64'(in_ready), 64'b01000);
        @(posedge clk); #1;
        in_valid = '0;
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
